// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the combinational ALU.
// Captures {Result, Z, C, N, OF, Tag} through valid/ready and keeps them in a
// 2-entry skid buffer (main + skid). ready_o comes straight from a flop, so the
// ALU never sees a combinational path from the downstream ready.
// Also keeps sticky carry/overflow flags and a delivered-results counter.

package alu_pipelined_pkg;
  localparam int unsigned WIDTH = 32;
endpackage

module alu_result_stage #(
  parameter int unsigned WIDTH = alu_pipelined_pkg::WIDTH,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // upstream (ALU) side
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] Result_i,
  input  logic             Z_i,
  input  logic             C_i,
  input  logic             N_i,
  input  logic             OF_i,
  input  logic [TAG_W-1:0] Tag_i,
  // downstream (writeback / flag register) side
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] Result_o,
  output logic             Z_o,
  output logic             C_o,
  output logic             N_o,
  output logic             OF_o,
  output logic [TAG_W-1:0] Tag_o,
  // sticky flags and delivery counter
  input  logic             clear_i,
  output logic             StickyC_o,
  output logic             StickyOF_o,
  output logic [CNT_W-1:0] Count_o
);

  // Packed payload layout: {Result, Z, C, N, OF, Tag}
  localparam int unsigned PW     = WIDTH + 4 + TAG_W;
  localparam int unsigned OF_BIT = TAG_W;
  localparam int unsigned N_BIT  = TAG_W + 1;
  localparam int unsigned C_BIT  = TAG_W + 2;
  localparam int unsigned Z_BIT  = TAG_W + 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    main_q, main_d;
  logic [PW-1:0]    skid_q, skid_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             sticky_c_q, sticky_c_d;
  logic             sticky_of_q, sticky_of_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PW-1:0]    in_payload;
  logic             accept;
  logic             take;

  assign in_payload = {Result_i, Z_i, C_i, N_i, OF_i, Tag_i};

  // Handshakes use only the registered ready/valid, never a through-path.
  assign accept = valid_i & ready_q;
  assign take   = valid_q & ready_i;

  // Skid-buffer next-state: decide where an accepted item lands and when skid moves up.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_payload;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept && !take) begin
          // downstream stalled: park the new item behind main
          skid_d  = in_payload;
          state_d = ST_TWO;
        end else if (take && !accept) begin
          state_d = ST_EMPTY;
        end else if (accept && take) begin
          // streaming: main is consumed and refilled in the same cycle
          main_d  = in_payload;
          state_d = ST_ONE;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        // ready is low here, so accept cannot happen; only drain skid into main
        if (take) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Handshake outputs are registered copies decoded from the next state.
  always_comb begin
    valid_d = 1'b0;
    ready_d = 1'b1;
    case (state_d)
      ST_EMPTY: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
      ST_ONE: begin
        valid_d = 1'b1;
        ready_d = 1'b1;
      end
      ST_TWO: begin
        valid_d = 1'b1;
        ready_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // Sticky flags: a set in the same cycle as clear wins so no event is lost.
  always_comb begin
    sticky_c_d  = (sticky_c_q  & ~clear_i) | (accept & C_i);
    sticky_of_d = (sticky_of_q & ~clear_i) | (accept & OF_i);
  end

  // Delivered-results counter, wraps naturally at 2^CNT_W.
  always_comb begin
    if (take) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // State and data registers with synchronous reset taking priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      main_q      <= {PW{1'b0}};
      skid_q      <= {PW{1'b0}};
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      sticky_c_q  <= 1'b0;
      sticky_of_q <= 1'b0;
      count_q     <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      sticky_c_q  <= sticky_c_d;
      sticky_of_q <= sticky_of_d;
      count_q     <= count_d;
    end
  end

  // Outputs come directly from flops.
  assign ready_o    = ready_q;
  assign valid_o    = valid_q;
  assign Result_o   = main_q[PW-1 -: WIDTH];
  assign Z_o        = main_q[Z_BIT];
  assign C_o        = main_q[C_BIT];
  assign N_o        = main_q[N_BIT];
  assign OF_o       = main_q[OF_BIT];
  assign Tag_o      = main_q[TAG_W-1:0];
  assign StickyC_o  = sticky_c_q;
  assign StickyOF_o = sticky_of_q;
  assign Count_o    = count_q;

endmodule
